// File: rtl/gpio_irq.sv
// gpio_irq -- memory-mapped GPIO port with input synchroniser, per-pin edge
// detection and a sticky interrupt flag register.
//
// Register map (offset from GPIO_ADDRESS):
//   +0 DIR       R/W  1 = pin driven from port
//   +1 PORT      R/W  output data
//   +2 PINS      RO   synchronised pad inputs (sync2)
//   +3 IRQ_EN    R/W  per-pin interrupt enable
//   +4 EDGE_SEL  R/W  1 = rising edge, 0 = falling edge
//   +5 FLAGS     R/W1C sticky edge flags
//   +6 PORT_TGL  WO   port <= port ^ din; reads return 0
//
// Ports:
//   clk      system clock, all logic on posedge
//   rst      synchronous active-high reset
//   din      write data
//   address  register address
//   w_en     write strobe
//   r_en     read strobe
//   dout     registered read data, valid one cycle after r_en
//   dir      pin direction
//   port     output data value
//   pins     asynchronous pad inputs
//   irq      OR of all flag bits
//
// Bus handshake: there is no stall. A strobe (w_en or r_en) sampled high at a
// rising edge with a decoded address completes at that edge; writes update
// state at that edge and read data appears on dout right after it. Bus bits
// above WIDTH read as 0 and are ignored on writes.
module gpio_irq #(
  parameter logic [7:0] GPIO_ADDRESS = 8'h00,
  parameter int         WIDTH        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       din,
  input  logic [7:0]       address,
  input  logic             w_en,
  input  logic             r_en,
  output logic [7:0]       dout,
  output logic [WIDTH-1:0] dir,
  output logic [WIDTH-1:0] port,
  input  logic [WIDTH-1:0] pins,
  output logic             irq
);

  localparam logic [2:0] OFF_DIR      = 3'd0;
  localparam logic [2:0] OFF_PORT     = 3'd1;
  localparam logic [2:0] OFF_PINS     = 3'd2;
  localparam logic [2:0] OFF_IRQ_EN   = 3'd3;
  localparam logic [2:0] OFF_EDGE_SEL = 3'd4;
  localparam logic [2:0] OFF_FLAGS    = 3'd5;
  localparam logic [2:0] OFF_PORT_TGL = 3'd6;

  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] port_q, port_d;
  logic [WIDTH-1:0] irq_en_q, irq_en_d;
  logic [WIDTH-1:0] edge_sel_q, edge_sel_d;
  logic [WIDTH-1:0] flags_q, flags_d;
  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
  logic [1:0]       settle_q, settle_d;
  logic [7:0]       dout_q, dout_d;

  // Offset wraps modulo 256, so a base near the top of the map still decodes.
  logic [7:0]       offset;
  logic [2:0]       reg_sel;
  logic             decoded;
  logic [WIDTH-1:0] wdata;
  logic [7:0]       rd_data;
  logic [WIDTH-1:0] rise, fall, hit, w1c_mask;
  logic             settled;

  assign offset  = address - GPIO_ADDRESS;
  assign decoded = (offset < 8'd7);
  assign reg_sel = offset[2:0];
  assign wdata   = din[WIDTH-1:0];

  // Edge detection against the previous synchronised sample. Hits are held
  // off until the pipeline has refilled after reset, so pads already high
  // at reset release do not look like rising edges.
  assign settled = (settle_q == 2'd3);
  assign rise    = sync2_q & ~prev_q;
  assign fall    = ~sync2_q & prev_q;
  assign hit     = settled ? (irq_en_q & ((edge_sel_q & rise) | (~edge_sel_q & fall)))
                           : '0;

  // Read mux works off current register values, so a simultaneous write
  // to the same register returns the old contents.
  always_comb begin
    rd_data = '0;
    case (reg_sel)
      OFF_DIR:      rd_data[WIDTH-1:0] = dir_q;
      OFF_PORT:     rd_data[WIDTH-1:0] = port_q;
      OFF_PINS:     rd_data[WIDTH-1:0] = sync2_q;
      OFF_IRQ_EN:   rd_data[WIDTH-1:0] = irq_en_q;
      OFF_EDGE_SEL: rd_data[WIDTH-1:0] = edge_sel_q;
      OFF_FLAGS:    rd_data[WIDTH-1:0] = flags_q;
      default:      rd_data = '0;
    endcase
  end

  always_comb begin
    dir_d      = dir_q;
    port_d     = port_q;
    irq_en_d   = irq_en_q;
    edge_sel_d = edge_sel_q;
    w1c_mask   = '0;
    dout_d     = dout_q;
    settle_d   = settled ? settle_q : settle_q + 2'd1;

    if (w_en && decoded) begin
      case (reg_sel)
        OFF_DIR:      dir_d      = wdata;
        OFF_PORT:     port_d     = wdata;
        OFF_IRQ_EN:   irq_en_d   = wdata;
        OFF_EDGE_SEL: edge_sel_d = wdata;
        OFF_FLAGS:    w1c_mask   = wdata;
        OFF_PORT_TGL: port_d     = port_q ^ wdata;
        default:      ;
      endcase
    end

    if (r_en && decoded) dout_d = rd_data;

    // New hits are ORed in after the clear, so a set beats a W1C.
    flags_d = (flags_q & ~w1c_mask) | hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q      <= '0;
      port_q     <= '0;
      irq_en_q   <= '0;
      edge_sel_q <= '0;
      flags_q    <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      settle_q   <= '0;
      dout_q     <= '0;
    end else begin
      dir_q      <= dir_d;
      port_q     <= port_d;
      irq_en_q   <= irq_en_d;
      edge_sel_q <= edge_sel_d;
      flags_q    <= flags_d;
      sync1_q    <= pins;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      settle_q   <= settle_d;
      dout_q     <= dout_d;
    end
  end

  assign dout = dout_q;
  assign dir  = dir_q;
  assign port = port_q;
  assign irq  = |flags_q;

endmodule

// File: tb/tb_gpio_irq.sv
module tb_gpio_irq;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic [7:0] address;
  logic       w_en;
  logic       r_en;
  logic [7:0] dout;
  logic [7:0] dir;
  logic [7:0] port;
  logic [7:0] pins;
  logic       irq;

  logic [7:0] dout4;
  logic [3:0] dir4;
  logic [3:0] port4;
  logic [3:0] pins4;
  logic       irq4;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  gpio_irq #(.GPIO_ADDRESS(8'h00), .WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .din(din), .address(address), .w_en(w_en), .r_en(r_en),
    .dout(dout), .dir(dir), .port(port), .pins(pins), .irq(irq)
  );

  gpio_irq #(.GPIO_ADDRESS(8'h20), .WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .din(din), .address(address), .w_en(w_en), .r_en(r_en),
    .dout(dout4), .dir(dir4), .port(port4), .pins(pins4), .irq(irq4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change 1 time unit after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    address = a;
    din     = d;
    w_en    = 1'b1;
    tick();
    w_en    = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a);
    address = a;
    r_en    = 1'b1;
    tick();
    r_en    = 1'b0;
  endtask

  // scoreboard read: expected value queued, then compared against dout
  task automatic read_chk(input logic [7:0] a, input logic [7:0] e, input string tag);
    exp_q.push_back(e);
    bus_read(a);
    check(tag, dout, exp_q.pop_front());
  endtask

  initial begin
    rst = 1'b1; din = '0; address = '0; w_en = 1'b0; r_en = 1'b0;
    pins = '0; pins4 = '0;
    ticks(2);
    check("rst_irq",   {7'd0, irq}, 8'h00);
    check("rst_dout",  dout, 8'h00);
    check("rst_dir",   dir,  8'h00);
    check("rst_port",  port, 8'h00);
    check("rst_dout4", dout4, 8'h00);
    rst = 1'b0;

    // every offset reads zero after reset
    for (int i = 0; i < 7; i++) read_chk(8'(i), 8'h00, "rst_read");
    check("rst_irq2", {7'd0, irq}, 8'h00);

    // direction, port and toggle
    bus_write(8'h00, 8'hF0);
    check("dir_out", dir, 8'hF0);
    bus_write(8'h01, 8'h5A);
    check("port_out", port, 8'h5A);
    bus_write(8'h06, 8'hFF);
    check("port_tgl", port, 8'hA5);
    read_chk(8'h00, 8'hF0, "rd_dir");
    read_chk(8'h01, 8'hA5, "rd_port");
    read_chk(8'h06, 8'h00, "rd_tgl");

    // undecoded addresses: writes ignored, read leaves dout alone
    bus_write(8'h07, 8'hFF);
    bus_write(8'h08, 8'hFF);
    read_chk(8'h00, 8'hF0, "undec_wr");
    bus_read(8'h09);
    check("undec_rd_hold", dout, 8'hF0);

    // read and write of the same register in one cycle returns old data
    address = 8'h00; din = 8'h33; w_en = 1'b1; r_en = 1'b1;
    tick();
    w_en = 1'b0; r_en = 1'b0;
    check("rw_old", dout, 8'hF0);
    check("rw_dir", dir,  8'h33);

    // PINS readback shows the pad value two edges later
    pins = 8'h3C;
    read_chk(8'h02, 8'h00, "pins_d1");
    read_chk(8'h02, 8'h00, "pins_d2");
    read_chk(8'h02, 8'h3C, "pins_d3");

    // rising edge on bit 0: flag two edges after sync1 captures it
    pins = 8'h00;
    ticks(3);
    bus_write(8'h03, 8'h01);
    bus_write(8'h04, 8'h01);
    check("irq_idle", {7'd0, irq}, 8'h00);
    pins = 8'h01;
    tick();
    check("rise_k",  {7'd0, irq}, 8'h00);
    tick();
    check("rise_k1", {7'd0, irq}, 8'h00);
    tick();
    check("rise_k2", {7'd0, irq}, 8'h01);
    read_chk(8'h05, 8'h01, "flags_b0");
    bus_write(8'h05, 8'h01);
    check("w1c_irq", {7'd0, irq}, 8'h00);

    // bit 3 falling-edge select: rising edge ignored, falling edge flagged
    bus_write(8'h03, 8'h08);
    bus_write(8'h04, 8'h00);
    pins = 8'h09;
    ticks(4);
    check("fall_sel_rise", {7'd0, irq}, 8'h00);
    read_chk(8'h05, 8'h00, "flags_none");
    pins = 8'h01;
    ticks(2);
    check("fall_k1", {7'd0, irq}, 8'h00);
    tick();
    check("fall_k2", {7'd0, irq}, 8'h01);
    read_chk(8'h05, 8'h08, "flags_b3");
    bus_write(8'h05, 8'h08);
    check("w1c_b3", {7'd0, irq}, 8'h00);

    // edge and W1C of the same bit in one cycle: set wins
    pins = 8'h09;
    ticks(4);
    check("pre_collide", {7'd0, irq}, 8'h00);
    pins = 8'h01;
    ticks(2);
    bus_write(8'h05, 8'h08);
    check("collide_irq", {7'd0, irq}, 8'h01);
    read_chk(8'h05, 8'h08, "collide_flags");

    // narrow instance: upper bits read 0, toggle stays in range
    bus_write(8'h20, 8'hFF);
    check("w4_dir", {4'd0, dir4}, 8'h0F);
    bus_read(8'h20);
    check("w4_rd_dir", dout4, 8'h0F);
    check("w4_main_hold", dout, 8'h08);
    bus_write(8'h26, 8'hFF);
    check("w4_tgl", {4'd0, port4}, 8'h0F);

    // reset mid-operation with pads held high through release
    pins = 8'hFF;
    rst = 1'b1;
    tick();
    check("mid_rst_irq",   {7'd0, irq}, 8'h00);
    check("mid_rst_dir",   dir,  8'h00);
    check("mid_rst_port",  port, 8'h00);
    check("mid_rst_dout",  dout, 8'h00);
    check("mid_rst_dir4",  {4'd0, dir4}, 8'h00);
    check("mid_rst_port4", {4'd0, port4}, 8'h00);
    check("mid_rst_dout4", dout4, 8'h00);
    rst = 1'b0;
    bus_write(8'h03, 8'hFF);
    bus_write(8'h04, 8'hFF);
    ticks(4);
    check("settle_irq", {7'd0, irq}, 8'h00);
    read_chk(8'h05, 8'h00, "settle_flags");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
